ahblite_busmatrix_inputstage_dma: RTL and testbench
===================================================

Name: ahblite_busmatrix_inputstage_dma

Overview:
- Master-side input stage for the DMA port of the AHB-Lite bus matrix; sits between the DMA master and the DMA address decoder.
- Forwards the address phase to the decoder when the target output stage is free.
- When the decoder reports the target busy (ACTIVE low), the stage latches the address-phase controls and inserts wait states to the DMA master until the transfer is accepted.
- Tracks the forwarded data phase and returns HREADY/HRESP to the master.

Parameters:
- ADDR_W, 32, address width; matches decoder HADDR.

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  master-side slave select for this port
- HADDR  in  ADDR_W  master address
- HTRANS  in  2  master transfer type
- HWRITE  in  1  master write flag
- HSIZE  in  3  master size
- HBURST  in  3  master burst
- HPROT  in  4  master protection
- HMASTLOCK  in  1  master lock
- HREADY  in  1  master-segment bus HREADY, i.e. this stage's HREADYOUT fed back
- HREADYOUT  out  1  ready to master
- HRESP  out  2  response to master
- HADDR_o  out  ADDR_W  address to decoder
- HTRANS_o  out  2  transfer type to decoder
- HWRITE_o  out  1  to decoder
- HSIZE_o  out  3  to decoder
- HBURST_o  out  3  to decoder
- HPROT_o  out  4  to decoder
- HMASTLOCK_o  out  1  to decoder
- HREADY_o  out  1  HREADY to decoder; equals HREADYOUT_Decoder
- ACTIVE_Decoder  in  1  target output stage currently grants this master
- HREADYOUT_Decoder  in  1  decoder ready
- HRESP_Decoder  in  2  decoder response

Behaviour:
- req_live = HSEL & HTRANS[1] & HREADY. A new address phase is only valid while HREADY is high.
- Holding register:
  - Captures HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT and HMASTLOCK on every cycle where req_live=1.
  - Captures only when pend=0.
- Forward mux:
  - pend=1: outputs come from the holding register.
  - pend=0: outputs pass the live inputs; HTRANS_o = HSEL ? HTRANS : IDLE (2'b00).
- accept = HTRANS_o[1] & ACTIVE_Decoder & HREADYOUT_Decoder.
- State (two flags, pend and dphase), next-state:
  - pend: set when req_live & ~accept; clear when pend & accept. Both conditions in one cycle cannot occur, because req_live needs HREADY=1 and HREADYOUT=0 while pend=1.
  - dphase: set on accept; clear when HREADYOUT_Decoder=1 & ~accept.
- Master outputs:
  - HREADYOUT = pend ? 0 : (dphase ? HREADYOUT_Decoder : 1).
  - HRESP = dphase ? HRESP_Decoder : 2'b00 (OKAY). When pend=1 and dphase=1, HRESP tracks the previous transfer's response while HREADYOUT is held 0.
- Latency: zero-cycle combinational pass-through when the target is free and pend=0. One or more wait states while pend=1.
- Reset mid-operation: pend=0, dphase=0 and holding register cleared (HTRANS held = IDLE) asynchronously. Afterwards HREADYOUT=1, HRESP=OKAY and HTRANS_o=IDLE until the next valid request.
- Reset values: HREADYOUT=1, HRESP=2'b00, HTRANS_o=2'b00, all other _o = 0 while HSEL=0.
- IDLE/BUSY transfers (HTRANS[1]=0) are never held. They are passed live and need no acceptance.
- ERROR response without the feature: the pending transfer is kept and issued once ACTIVE rises.

Optional Feature:
- INPUTSTAGE_ERR_CANCEL_EN: when defined, if HRESP_Decoder=ERROR & HREADYOUT_Decoder=0 (first ERROR cycle) while pend=1, the held transfer is cancelled.
  - Effect: pend cleared and held HTRANS set to IDLE.
  - Result: the master's retry or abort on the second ERROR cycle is taken live.
- When undefined, the held transfer is kept and issued normally.

Decomposition:
- Shared package ahb_matrix_pkg:
  - HTRANS encodings: IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
  - HRESP encodings: OKAY 00, ERROR 01.
  - Control field widths.
- One natural sub-module: ahblite_addr_hold, the resettable holding register plus forward mux.
- Flags and response logic stay in the top module.

Test Plan:
- Free target: NONSEQ 0x20000010 read with ACTIVE=1, decoder ready. Expect HTRANS_o=NONSEQ in the same cycle, HREADYOUT=1, pend never set, dphase high for 1 cycle.
- Busy target: NONSEQ write 0x40010004 with ACTIVE=0 for 3 cycles. Expect HREADYOUT=0 for 3 cycles and HADDR_o held at 0x40010004 even after the master changes HADDR. Accept in cycle 4, then pend=0.
- Slave wait states: accepted transfer, HREADYOUT_Decoder low for 2 cycles. Expect HREADYOUT low for 2 cycles, then high; back-to-back SEQ 0x20000014 forwarded on the ready cycle.
- Error response: HRESP_Decoder=ERROR for 2 cycles (ready 0 then 1). Expect HRESP=01 both cycles. With INPUTSTAGE_ERR_CANCEL_EN and pend=1, expect the held transfer dropped and HTRANS_o=IDLE.
- Reset mid-operation: assert HRESETn=0 while pend=1. Expect HREADYOUT=1 and HTRANS_o=IDLE immediately (asynchronous), and no stale transfer after release.
- IDLE with HSEL=1 and ACTIVE=0: expect no pend, HREADYOUT=1, HRESP=OKAY.

Source files
------------

// File: rtl/ahb_matrix_pkg.sv
// Shared AHB-Lite bus-matrix encodings and control-field bundle used by the
// input stages and their address-hold registers.
package ahb_matrix_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;

   localparam int TRANS_W = 2;
   localparam int SIZE_W  = 3;
   localparam int BURST_W = 3;
   localparam int PROT_W  = 4;
   localparam int RESP_W  = 2;

   // Address-phase controls travel together through the hold register.
   typedef struct packed {
      logic [TRANS_W-1:0] trans;
      logic               write;
      logic [SIZE_W-1:0]  size;
      logic [BURST_W-1:0] burst;
      logic [PROT_W-1:0]  prot;
      logic               lock;
   } ahb_ctrl_t;

endpackage

// File: rtl/ahblite_addr_hold.sv
// Address-phase holding register and forward mux: replays the captured
// transfer while a request is pending, otherwise passes the master live.
module ahblite_addr_hold
   import ahb_matrix_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              capture,
   input  logic              cancel,
   input  logic              pend,
   input  logic              hsel,
   input  logic [ADDR_W-1:0] haddr_i,
   input  ahb_ctrl_t         ctrl_i,
   output logic [ADDR_W-1:0] haddr_o,
   output ahb_ctrl_t         ctrl_o
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   ahb_ctrl_t         ctrl_q, ctrl_d;

   always_comb begin
      addr_d = addr_q;
      ctrl_d = ctrl_q;
      if (capture) begin
         addr_d = haddr_i;
         ctrl_d = ctrl_i;
      end
      // A cancelled hold must never be replayed, so only the transfer type is killed.
      if (cancel) begin
         ctrl_d.trans = HTRANS_IDLE;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         addr_q <= '0;
         ctrl_q <= '0;
      end else begin
         addr_q <= addr_d;
         ctrl_q <= ctrl_d;
      end
   end

   always_comb begin
      haddr_o = '0;
      ctrl_o  = '0;
      if (pend) begin
         haddr_o = addr_q;
         ctrl_o  = ctrl_q;
      end else if (hsel) begin
         haddr_o = haddr_i;
         ctrl_o  = ctrl_i;
      end
   end

endmodule

// File: rtl/ahblite_busmatrix_inputstage_dma.sv
// DMA-port input stage of the AHB-Lite bus matrix. Optional build macro
// INPUTSTAGE_ERR_CANCEL_EN drops a held transfer on a first ERROR cycle.
module ahblite_busmatrix_inputstage_dma
   import ahb_matrix_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic               HCLK,
   input  logic               HRESETn,
   input  logic               HSEL,
   input  logic [ADDR_W-1:0]  HADDR,
   input  logic [TRANS_W-1:0] HTRANS,
   input  logic               HWRITE,
   input  logic [SIZE_W-1:0]  HSIZE,
   input  logic [BURST_W-1:0] HBURST,
   input  logic [PROT_W-1:0]  HPROT,
   input  logic               HMASTLOCK,
   input  logic               HREADY,
   output logic               HREADYOUT,
   output logic [RESP_W-1:0]  HRESP,
   output logic [ADDR_W-1:0]  HADDR_o,
   output logic [TRANS_W-1:0] HTRANS_o,
   output logic               HWRITE_o,
   output logic [SIZE_W-1:0]  HSIZE_o,
   output logic [BURST_W-1:0] HBURST_o,
   output logic [PROT_W-1:0]  HPROT_o,
   output logic               HMASTLOCK_o,
   output logic               HREADY_o,
   input  logic               ACTIVE_Decoder,
   input  logic               HREADYOUT_Decoder,
   input  logic [RESP_W-1:0]  HRESP_Decoder
);

   logic      pend_q, pend_d;
   logic      dphase_q, dphase_d;
   logic      req_live, accept, capture, cancel;
   ahb_ctrl_t ctrl_live, ctrl_fwd;

   assign req_live = HSEL & HTRANS[1] & HREADY;
   assign accept   = HTRANS_o[1] & ACTIVE_Decoder & HREADYOUT_Decoder;
   assign capture  = req_live & ~pend_q;

`ifdef INPUTSTAGE_ERR_CANCEL_EN
   assign cancel = pend_q & (HRESP_Decoder == HRESP_ERROR) & ~HREADYOUT_Decoder;
`else
   assign cancel = 1'b0;
`endif

   assign ctrl_live = '{trans: HTRANS, write: HWRITE, size: HSIZE,
                        burst: HBURST, prot: HPROT, lock: HMASTLOCK};

   ahblite_addr_hold #(
      .ADDR_W (ADDR_W)
   ) u_addr_hold (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .capture (capture),
      .cancel  (cancel),
      .pend    (pend_q),
      .hsel    (HSEL),
      .haddr_i (HADDR),
      .ctrl_i  (ctrl_live),
      .haddr_o (HADDR_o),
      .ctrl_o  (ctrl_fwd)
   );

   assign HTRANS_o    = ctrl_fwd.trans;
   assign HWRITE_o    = ctrl_fwd.write;
   assign HSIZE_o     = ctrl_fwd.size;
   assign HBURST_o    = ctrl_fwd.burst;
   assign HPROT_o     = ctrl_fwd.prot;
   assign HMASTLOCK_o = ctrl_fwd.lock;
   assign HREADY_o    = HREADYOUT_Decoder;

   // Set and clear of pend are mutually exclusive: a live request needs
   // HREADY high, which this stage holds low while pending.
   always_comb begin
      pend_d = pend_q;
      if (req_live & ~accept) begin
         pend_d = 1'b1;
      end else if (pend_q & accept) begin
         pend_d = 1'b0;
      end
      if (cancel) begin
         pend_d = 1'b0;
      end
   end

   always_comb begin
      dphase_d = dphase_q;
      if (accept) begin
         dphase_d = 1'b1;
      end else if (HREADYOUT_Decoder) begin
         dphase_d = 1'b0;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         pend_q   <= 1'b0;
         dphase_q <= 1'b0;
      end else begin
         pend_q   <= pend_d;
         dphase_q <= dphase_d;
      end
   end

   assign HREADYOUT = pend_q ? 1'b0 : (dphase_q ? HREADYOUT_Decoder : 1'b1);
   assign HRESP     = dphase_q ? HRESP_Decoder : HRESP_OKAY;

endmodule

// File: tb/tb_ahblite_busmatrix_inputstage_dma.sv
// Directed bench for the DMA input stage; the master segment's HREADY is
// this stage's HREADYOUT looped back, the decoder side is driven directly.
module tb_ahblite_busmatrix_inputstage_dma;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic        HMASTLOCK;
   logic        HREADYOUT;
   logic [1:0]  HRESP;
   logic [31:0] HADDR_o;
   logic [1:0]  HTRANS_o;
   logic        HWRITE_o;
   logic [2:0]  HSIZE_o;
   logic [2:0]  HBURST_o;
   logic [3:0]  HPROT_o;
   logic        HMASTLOCK_o;
   logic        HREADY_o;
   logic        ACTIVE_Decoder;
   logic        HREADYOUT_Decoder;
   logic [1:0]  HRESP_Decoder;

   int checks = 0;
   int errors = 0;

   always #5 HCLK = ~HCLK;

   ahblite_busmatrix_inputstage_dma #(.ADDR_W(32)) dut (
      .HCLK              (HCLK),
      .HRESETn           (HRESETn),
      .HSEL              (HSEL),
      .HADDR             (HADDR),
      .HTRANS            (HTRANS),
      .HWRITE            (HWRITE),
      .HSIZE             (HSIZE),
      .HBURST            (HBURST),
      .HPROT             (HPROT),
      .HMASTLOCK         (HMASTLOCK),
      .HREADY            (HREADYOUT),
      .HREADYOUT         (HREADYOUT),
      .HRESP             (HRESP),
      .HADDR_o           (HADDR_o),
      .HTRANS_o          (HTRANS_o),
      .HWRITE_o          (HWRITE_o),
      .HSIZE_o           (HSIZE_o),
      .HBURST_o          (HBURST_o),
      .HPROT_o           (HPROT_o),
      .HMASTLOCK_o       (HMASTLOCK_o),
      .HREADY_o          (HREADY_o),
      .ACTIVE_Decoder    (ACTIVE_Decoder),
      .HREADYOUT_Decoder (HREADYOUT_Decoder),
      .HRESP_Decoder     (HRESP_Decoder)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic master(input logic sel, input logic [1:0] trans,
                         input logic [31:0] addr, input logic write);
      HSEL   = sel;
      HTRANS = trans;
      HADDR  = addr;
      HWRITE = write;
   endtask

   task automatic dec(input logic active, input logic rdy, input logic [1:0] resp);
      ACTIVE_Decoder    = active;
      HREADYOUT_Decoder = rdy;
      HRESP_Decoder     = resp;
   endtask

   task automatic cyc(input string name);
      @(negedge HCLK);
      $display("t=%0t %s", $time, name);
   endtask

   initial begin
      HRESETn = 1'b0;
      master(1'b0, 2'b00, 32'h0, 1'b0);
      HSIZE = 3'd0; HBURST = 3'd0; HPROT = 4'd0; HMASTLOCK = 1'b0;
      dec(1'b0, 1'b1, 2'b00);
      #2;
      chk("rst_hreadyout", HREADYOUT, 1);
      chk("rst_hresp",     HRESP,     0);
      chk("rst_htrans_o",  HTRANS_o,  0);
      chk("rst_haddr_o",   HADDR_o,   0);
      chk("rst_hwrite_o",  HWRITE_o,  0);
      @(negedge HCLK);
      HRESETn = 1'b1;

      // Free target: zero-latency pass-through
      master(1'b1, 2'b10, 32'h2000_0010, 1'b0);
      dec(1'b1, 1'b1, 2'b00);
      #1;
      $display("t=%0t free target NONSEQ read", $time);
      chk("free_htrans_o",  HTRANS_o,  2);
      chk("free_haddr_o",   HADDR_o,   32'h2000_0010);
      chk("free_hreadyout", HREADYOUT, 1);
      cyc("free data phase");
      master(1'b1, 2'b00, 32'h0, 1'b0);
      dec(1'b1, 1'b1, 2'b01);
      #1;
      chk("free_dphase_hresp", HRESP,     1);
      chk("free_dphase_rdy",   HREADYOUT, 1);
      chk("free_idle_trans",   HTRANS_o,  0);
      cyc("free after data phase");
      #1;
      chk("free_dphase_done", HRESP, 0);
      dec(1'b0, 1'b1, 2'b00);

      // Busy target: three wait states, controls held
      cyc("busy NONSEQ write");
      master(1'b1, 2'b10, 32'h4001_0004, 1'b1);
      HSIZE = 3'd2; HBURST = 3'd1; HPROT = 4'h3;
      #1;
      chk("busy_live_trans", HTRANS_o,  2);
      chk("busy_live_addr",  HADDR_o,   32'h4001_0004);
      chk("busy_live_rdy",   HREADYOUT, 1);
      cyc("busy wait 1");
      master(1'b1, 2'b10, 32'hDEAD_BEE0, 1'b0);
      HSIZE = 3'd0; HBURST = 3'd0; HPROT = 4'h0;
      #1;
      chk("busy_w1_rdy",   HREADYOUT, 0);
      chk("busy_w1_addr",  HADDR_o,   32'h4001_0004);
      chk("busy_w1_write", HWRITE_o,  1);
      chk("busy_w1_size",  HSIZE_o,   2);
      chk("busy_w1_burst", HBURST_o,  1);
      chk("busy_w1_prot",  HPROT_o,   3);
      chk("busy_w1_trans", HTRANS_o,  2);
      cyc("busy wait 2");
      #1;
      chk("busy_w2_rdy",  HREADYOUT, 0);
      chk("busy_w2_addr", HADDR_o,   32'h4001_0004);
      cyc("busy wait 3 accept");
      dec(1'b1, 1'b1, 2'b00);
      #1;
      chk("busy_w3_rdy",  HREADYOUT, 0);
      chk("busy_w3_addr", HADDR_o,   32'h4001_0004);
      cyc("busy data phase");
      master(1'b1, 2'b00, 32'h0, 1'b0);
      #1;
      chk("busy_dp_rdy",   HREADYOUT, 1);
      chk("busy_dp_trans", HTRANS_o,  0);

      // Slave wait states, then back-to-back SEQ on the ready cycle
      cyc("slave-wait NONSEQ");
      master(1'b1, 2'b10, 32'h2000_0010, 1'b0);
      #1;
      chk("sw_trans", HTRANS_o, 2);
      cyc("slave-wait 1");
      master(1'b1, 2'b11, 32'h2000_0014, 1'b0);
      dec(1'b1, 1'b0, 2'b00);
      #1;
      chk("sw_w1_rdy",      HREADYOUT, 0);
      chk("sw_w1_hready_o", HREADY_o,  0);
      cyc("slave-wait 2");
      #1;
      chk("sw_w2_rdy", HREADYOUT, 0);
      cyc("slave ready, SEQ forwarded");
      dec(1'b1, 1'b1, 2'b00);
      #1;
      chk("sw_rdy",       HREADYOUT, 1);
      chk("sw_seq_trans", HTRANS_o,  3);
      chk("sw_seq_addr",  HADDR_o,   32'h2000_0014);
      cyc("SEQ data phase");
      master(1'b1, 2'b00, 32'h0, 1'b0);
      #1;
      chk("sw_seq_dp_rdy", HREADYOUT, 1);

      // Two-cycle ERROR response with a transfer going pending behind it
      cyc("err NONSEQ");
      master(1'b1, 2'b10, 32'h2000_0020, 1'b0);
      cyc("err cycle 1");
      master(1'b1, 2'b10, 32'h3000_0000, 1'b1);
      dec(1'b0, 1'b0, 2'b01);
      #1;
      chk("err1_hresp", HRESP,     1);
      chk("err1_rdy",   HREADYOUT, 0);
      cyc("err cycle 2");
      dec(1'b0, 1'b1, 2'b01);
      #1;
      chk("err2_hresp", HRESP,     1);
      chk("err2_rdy",   HREADYOUT, 1);
      cyc("pending, decoder first ERROR cycle");
      dec(1'b0, 1'b0, 2'b01);
      #1;
      chk("perr_rdy",   HREADYOUT, 0);
      chk("perr_hresp", HRESP,     0);
      chk("perr_trans", HTRANS_o,  2);
      chk("perr_addr",  HADDR_o,   32'h3000_0000);
      cyc("target frees up");
      master(1'b1, 2'b00, 32'h0, 1'b0);
      dec(1'b1, 1'b1, 2'b00);
      #1;
`ifdef INPUTSTAGE_ERR_CANCEL_EN
      chk("cancel_rdy",   HREADYOUT, 1);
      chk("cancel_trans", HTRANS_o,  0);
      chk("cancel_addr",  HADDR_o,   0);
`else
      chk("keep_rdy",   HREADYOUT, 0);
      chk("keep_trans", HTRANS_o,  2);
      chk("keep_addr",  HADDR_o,   32'h3000_0000);
      chk("keep_write", HWRITE_o,  1);
`endif
      cyc("after ERROR sequence");
      #1;
      chk("post_err_rdy",   HREADYOUT, 1);
      chk("post_err_trans", HTRANS_o,  0);
      chk("post_err_hresp", HRESP,     0);

      // Asynchronous reset while pending
      cyc("pend before reset");
      master(1'b1, 2'b10, 32'h5000_0000, 1'b0);
      dec(1'b0, 1'b1, 2'b00);
      #1;
      chk("pre_rst_rdy", HREADYOUT, 1);
      cyc("pending, master idle");
      master(1'b0, 2'b00, 32'h0, 1'b0);
      #1;
      chk("pend_rdy",   HREADYOUT, 0);
      chk("pend_trans", HTRANS_o,  2);
      chk("pend_addr",  HADDR_o,   32'h5000_0000);
      #1 HRESETn = 1'b0;
      #1;
      $display("t=%0t async reset asserted", $time);
      chk("arst_rdy",   HREADYOUT, 1);
      chk("arst_trans", HTRANS_o,  0);
      chk("arst_addr",  HADDR_o,   0);
      @(negedge HCLK);
      HRESETn = 1'b1;
      dec(1'b1, 1'b1, 2'b00);
      #1;
      $display("t=%0t reset released", $time);
      chk("rel_rdy",   HREADYOUT, 1);
      chk("rel_trans", HTRANS_o,  0);
      cyc("no stale transfer");
      dec(1'b1, 1'b0, 2'b01);
      #1;
      chk("stale_rdy",   HREADYOUT, 1);
      chk("stale_hresp", HRESP,     0);
      chk("stale_trans", HTRANS_o,  0);

      // IDLE and BUSY are never held, even with the target busy
      cyc("IDLE selected, target busy");
      master(1'b1, 2'b00, 32'h6000_0000, 1'b0);
      dec(1'b0, 1'b1, 2'b00);
      #1;
      chk("idle_trans", HTRANS_o,  0);
      chk("idle_addr",  HADDR_o,   32'h6000_0000);
      chk("idle_rdy",   HREADYOUT, 1);
      cyc("BUSY selected, target busy");
      master(1'b1, 2'b01, 32'h6000_0004, 1'b0);
      #1;
      chk("busyt_trans", HTRANS_o,  1);
      chk("busyt_rdy",   HREADYOUT, 1);
      chk("busyt_hresp", HRESP,     0);
      cyc("after IDLE/BUSY");
      master(1'b1, 2'b00, 32'h0, 1'b0);
      #1;
      chk("nohold_rdy",   HREADYOUT, 1);
      chk("nohold_hresp", HRESP,     0);
      chk("nohold_trans", HTRANS_o,  0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
